ram_responder: RTL and testbench
================================

Name: ram_responder

Overview:
Responder end of the CPU memory protocol: serves the CPU's level-held read requests with a one-cycle acknowledge, and commits single-cycle write pulses.
- Backs the full 4 KB CHIP-8 address space.
- After every reset, preloads the built-in 80-byte hex font before it accepts any traffic.
- Sits between cpu and the top level, as the memory-side endpoint of the mem_read*/mem_write* bus.

Parameters:
ADDR_W, 12, address width; array depth is 2**ADDR_W bytes.
DATA_W, 8, data width.
READ_LATENCY, 1, cycles from read acceptance to read_ack; legal range 1..7.
FONT_BASE, 12'h050, first address of the font preload.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
read  input  1  read request; initiator holds it high with a stable read_addr until it sees read_ack.
read_addr  input  ADDR_W  read byte address.
read_data  output  DATA_W  read result; valid in the read_ack cycle and held until the next ack.
read_ack  output  1  one-cycle read completion pulse.
write  input  1  single-cycle write strobe.
write_addr  input  ADDR_W  write byte address.
write_data  input  DATA_W  write byte.
init_done  output  1  high once the font preload is complete.

Behaviour:
- Reset values: read_ack=0, read_data=0, init_done=0, state=INIT, font counter=0, latency counter=0.
- Reset asserted at any point, including mid-read, abandons the outstanding read: no ack is issued, the state returns to INIT, and the font preload is rewritten.
- The RAM array itself has no reset; contents outside the font region are undefined after power-up.
- States: INIT, IDLE, WAIT, ACK.
- INIT:
  - Writes font byte k to FONT_BASE+k, one byte per cycle, k=0..79.
  - After byte 79 is written, moves to IDLE, and init_done goes high in that same cycle.
  - The first cycle after reset deassertion is k=0, so init_done rises exactly 80 cycles after reset deassertion.
  - CPU writes during INIT are dropped.
  - read is ignored during INIT; it is not queued and is serviced later only because the initiator holds it.
- IDLE: read=1 accepts the request: read_addr is latched and the cycle is counted as cycle 0. Go to WAIT if READ_LATENCY>1, else to ACK.
- WAIT: the latency counter advances each cycle; leave for ACK so that read_ack is high exactly in cycle READ_LATENCY.
- Array read:
  - The array is read at the clock edge ending cycle READ_LATENCY-1.
  - A write committed at that same edge to the latched address is forwarded (write-first).
  - read_data therefore reflects every write issued in cycles 0..READ_LATENCY-1.
- ACK: read_ack=1 for one cycle, with read_data updated in that cycle; then go to IDLE.
- Back-to-back reads: if read is still high in the IDLE cycle after ACK, that cycle accepts a new request.
  - With READ_LATENCY=1, the minimum ack spacing is 2 cycles.
- Writes:
  - Outside INIT, write=1 commits write_data to write_addr at that edge, in any state; there is no ack.
  - Writes may overwrite font bytes.
- Addresses wrap naturally at ADDR_W bits; there is no out-of-range case.
- read_addr changing while a read is outstanding is a protocol violation; the latched address is used.

Decomposition:
- Package chip8_pkg holds:
  - ADDR_W/DATA_W defaults.
  - FONT_BASE.
  - FONT_BYTES=80.
  - The 80-entry font constant: digits 0..F, 5 bytes each, starting F0 90 90 90 F0 for 0 and ending F0 80 F0 80 80 for F.
  - The responder state enum.
- One sub-module: font_rom, a combinational 80x8 table indexed by the 7-bit preload counter.
- The RAM array and the state machine stay in ram_responder.

Test Plan:
- Release reset at cycle 0 -> init_done=0 through cycle 79 and 1 at cycle 80. Reads then return: 0x050 -> 0xF0, 0x051 -> 0x90, 0x09F -> 0x80.
- Hold read=1, read_addr=0x050 from cycle 5 after reset release (READ_LATENCY=1) -> no read_ack before cycle 81; single ack at cycle 81 with read_data=0xF0.
- After init, write 0x200=0xA2 at cycle c, read 0x200 accepted at c+1 -> read_ack at c+2, read_data=0xA2. Hold read through the ack -> second ack at c+4, read_data=0xA2.
- READ_LATENCY=3: accept read 0x300 at cycle t, write 0x300=0x5C at t+2 -> read_ack only at t+3 with read_data=0x5C (forwarding).
- Write 0x050=0x00 at cycle 10 during INIT -> after init, read 0x050 returns 0xF0 (write dropped).
- READ_LATENCY=3: accept read at t, assert reset at t+1 for 2 cycles -> no read_ack ever for that request. read_data=0 and init_done=0 during reset; init_done rises 80 cycles after release.

Source files
------------

// File: rtl/chip8_pkg.sv
// Shared constants, font table and responder state type for the CHIP-8 memory side.
`timescale 1ns/1ps
package chip8_pkg;

    localparam int ADDR_W_DEF = 12;
    localparam int DATA_W_DEF = 8;
    localparam logic [11:0] FONT_BASE_DEF = 12'h050;
    localparam int FONT_BYTES = 80;

    // Hex digits 0..F, five rows each, high nibble carries the glyph.
    localparam logic [7:0] FONT [FONT_BYTES] = '{
        8'hF0, 8'h90, 8'h90, 8'h90, 8'hF0,
        8'h20, 8'h60, 8'h20, 8'h20, 8'h70,
        8'hF0, 8'h10, 8'hF0, 8'h80, 8'hF0,
        8'hF0, 8'h10, 8'hF0, 8'h10, 8'hF0,
        8'h90, 8'h90, 8'hF0, 8'h10, 8'h10,
        8'hF0, 8'h80, 8'hF0, 8'h10, 8'hF0,
        8'hF0, 8'h80, 8'hF0, 8'h90, 8'hF0,
        8'hF0, 8'h10, 8'h20, 8'h40, 8'h40,
        8'hF0, 8'h90, 8'hF0, 8'h90, 8'hF0,
        8'hF0, 8'h90, 8'hF0, 8'h10, 8'hF0,
        8'hF0, 8'h90, 8'hF0, 8'h90, 8'h90,
        8'hE0, 8'h90, 8'hE0, 8'h90, 8'hE0,
        8'hF0, 8'h80, 8'h80, 8'h80, 8'hF0,
        8'hE0, 8'h90, 8'h90, 8'h90, 8'hE0,
        8'hF0, 8'h80, 8'hF0, 8'h80, 8'hF0,
        8'hF0, 8'h80, 8'hF0, 8'h80, 8'h80
    };

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_WAIT,
        ST_ACK
    } resp_state_e;

endpackage

// File: rtl/font_rom.sv
// Combinational lookup of the built-in font, indexed by the preload counter.
`timescale 1ns/1ps
module font_rom
    import chip8_pkg::*;
(
    input  logic [6:0] idx_i,
    output logic [7:0] data_o
);

    always_comb begin
        data_o = '0;
        if (idx_i < 7'(FONT_BYTES)) begin
            data_o = FONT[idx_i];
        end
    end

endmodule

// File: rtl/ram_responder.sv
// Memory-side endpoint of the CPU bus: font preload after reset, latency-programmable
// reads with a one-cycle ack, and fire-and-forget single-cycle writes.
`timescale 1ns/1ps
module ram_responder
    import chip8_pkg::*;
#(
    parameter int                  ADDR_W       = ADDR_W_DEF,
    parameter int                  DATA_W       = DATA_W_DEF,
    parameter int                  READ_LATENCY = 1,
    parameter logic [ADDR_W-1:0]   FONT_BASE    = ADDR_W'(FONT_BASE_DEF)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              read,
    input  logic [ADDR_W-1:0] read_addr,
    output logic [DATA_W-1:0] read_data,
    output logic              read_ack,
    input  logic              write,
    input  logic [ADDR_W-1:0] write_addr,
    input  logic [DATA_W-1:0] write_data,
    output logic              init_done,
    output resp_state_e       state_dbg
);

    // Read handshake: the initiator raises read with a stable read_addr and holds both
    // until it sees read_ack; read_ack is a one-cycle pulse READ_LATENCY cycles after the
    // accepting IDLE cycle, and read_data holds its value until the next ack.
    localparam logic [2:0] LAST_CYC = 3'(READ_LATENCY - 1);

    resp_state_e       state_q;
    logic [6:0]        font_cnt_q;
    logic [2:0]        lat_cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] read_data_q;
    logic              read_ack_q;
    logic              init_done_q;

    logic [DATA_W-1:0] mem [2**ADDR_W];

    logic [7:0]        font_byte;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_fwd;

    font_rom u_font_rom (
        .idx_i  (font_cnt_q),
        .data_o (font_byte)
    );

    // The preload owns the single write port while INIT; CPU writes are dropped then.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = write_addr;
        mem_wdata = write_data;
        if (state_q == ST_INIT) begin
            mem_we    = 1'b1;
            mem_waddr = FONT_BASE + ADDR_W'(font_cnt_q);
            mem_wdata = DATA_W'(font_byte);
        end else if (write) begin
            mem_we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Write-first: a write landing on the read address at the sampling edge wins.
    always_comb begin
        rd_addr = (state_q == ST_IDLE) ? read_addr : addr_q;
        rd_fwd  = mem[rd_addr];
        if (state_q != ST_INIT && write && write_addr == rd_addr) begin
            rd_fwd = write_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_INIT;
            font_cnt_q  <= '0;
            lat_cnt_q   <= '0;
            addr_q      <= '0;
            read_data_q <= '0;
            read_ack_q  <= 1'b0;
            init_done_q <= 1'b0;
        end else begin
            read_ack_q <= 1'b0;
            case (state_q)
                ST_INIT: begin
                    font_cnt_q <= font_cnt_q + 7'd1;
                    if (font_cnt_q == 7'(FONT_BYTES - 1)) begin
                        state_q     <= ST_IDLE;
                        init_done_q <= 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (read) begin
                        addr_q <= read_addr;
                        if (READ_LATENCY == 1) begin
                            read_data_q <= rd_fwd;
                            read_ack_q  <= 1'b1;
                            state_q     <= ST_ACK;
                        end else begin
                            lat_cnt_q <= 3'd1;
                            state_q   <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (lat_cnt_q == LAST_CYC) begin
                        read_data_q <= rd_fwd;
                        read_ack_q  <= 1'b1;
                        state_q     <= ST_ACK;
                    end else begin
                        lat_cnt_q <= lat_cnt_q + 3'd1;
                    end
                end
                ST_ACK: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_INIT;
                end
            endcase
        end
    end

    assign read_data = read_data_q;
    assign read_ack  = read_ack_q;
    assign init_done = init_done_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_ram_responder.sv
// Bench for ram_responder: two instances (latency 1 and 3) on a shared write bus,
// checked against a byte-array memory model through per-instance expected queues.
`timescale 1ns/1ps
module tb_ram_responder;

  localparam int AW = 12;
  localparam int DW = 8;

  localparam logic [7:0] FONT_REF [80] = '{
    8'hF0, 8'h90, 8'h90, 8'h90, 8'hF0,  8'h20, 8'h60, 8'h20, 8'h20, 8'h70,
    8'hF0, 8'h10, 8'hF0, 8'h80, 8'hF0,  8'hF0, 8'h10, 8'hF0, 8'h10, 8'hF0,
    8'h90, 8'h90, 8'hF0, 8'h10, 8'h10,  8'hF0, 8'h80, 8'hF0, 8'h10, 8'hF0,
    8'hF0, 8'h80, 8'hF0, 8'h90, 8'hF0,  8'hF0, 8'h10, 8'h20, 8'h40, 8'h40,
    8'hF0, 8'h90, 8'hF0, 8'h90, 8'hF0,  8'hF0, 8'h90, 8'hF0, 8'h10, 8'hF0,
    8'hF0, 8'h90, 8'hF0, 8'h90, 8'h90,  8'hE0, 8'h90, 8'hE0, 8'h90, 8'hE0,
    8'hF0, 8'h80, 8'h80, 8'h80, 8'hF0,  8'hE0, 8'h90, 8'h90, 8'h90, 8'hE0,
    8'hF0, 8'h80, 8'hF0, 8'h80, 8'hF0,  8'hF0, 8'h80, 8'hF0, 8'h80, 8'h80
  };

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int cyc = 0;
  int rel = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          rd [2];
  logic [AW-1:0] rd_addr [2];
  logic [DW-1:0] rdata [2];
  logic          ack [2];
  logic          done [2];
  chip8_pkg::resp_state_e dbg [2];
  logic          wr;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;

  ram_responder #(.READ_LATENCY(1)) u_dut0 (
    .clk(clk), .reset(reset), .read(rd[0]), .read_addr(rd_addr[0]),
    .read_data(rdata[0]), .read_ack(ack[0]), .write(wr), .write_addr(wr_addr),
    .write_data(wr_data), .init_done(done[0]), .state_dbg(dbg[0])
  );

  ram_responder #(.READ_LATENCY(3)) u_dut1 (
    .clk(clk), .reset(reset), .read(rd[1]), .read_addr(rd_addr[1]),
    .read_data(rdata[1]), .read_ack(ack[1]), .write(wr), .write_addr(wr_addr),
    .write_data(wr_data), .init_done(done[1]), .state_dbg(dbg[1])
  );

  // reference model and scoreboard
  logic [7:0] mdl [4096];
  bit         known [4096];
  logic [DW-1:0] exp_q0 [$];
  logic [DW-1:0] exp_q1 [$];
  int checks = 0;
  int errors = 0;
  int ack_cnt [2];
  int last_ack [2];

  function automatic int lat(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // monitor: every ack pops one expectation from that instance's queue
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (ack[i] === 1'b1) begin
        ack_cnt[i]++;
        last_ack[i] = cyc;
        if (i == 0) begin
          if (exp_q0.size() == 0) chk("unexpected_ack0", 1, 0);
          else chk("rdata0", int'(rdata[0]), int'(exp_q0.pop_front()));
        end else begin
          if (exp_q1.size() == 0) chk("unexpected_ack1", 1, 0);
          else chk("rdata1", int'(rdata[1]), int'(exp_q1.pop_front()));
        end
      end
    end
  end

  // driver tasks
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int i, input logic [7:0] v);
    if (i == 0) exp_q0.push_back(v);
    else exp_q1.push_back(v);
  endtask

  task automatic model_font();
    for (int k = 0; k < 80; k++) begin
      mdl[12'h050 + k] = FONT_REF[k];
      known[12'h050 + k] = 1'b1;
    end
  endtask

  task automatic init_phase(input bit hold);
    int base0;
    int base1;
    base0 = ack_cnt[0];
    base1 = ack_cnt[1];
    reset = 1'b0;
    rel = cyc;
    for (int n = 0; n <= 85; n++) begin
      if (hold && n == 5) begin
        rd[0] = 1'b1; rd_addr[0] = 12'h050; push_exp(0, 8'hF0);
        rd[1] = 1'b1; rd_addr[1] = 12'h051; push_exp(1, 8'h90);
      end
      wr = (n == 10);
      wr_addr = 12'h050;
      wr_data = 8'h00;
      @(negedge clk);
      if (n <= 81) begin
        chk("init_done0", int'(done[0]), int'(n >= 80));
        chk("init_done1", int'(done[1]), int'(n >= 80));
      end
      next_cycle();
      if (rd[0] && ack_cnt[0] != base0) rd[0] = 1'b0;
      if (rd[1] && ack_cnt[1] != base1) rd[1] = 1'b0;
    end
    if (hold) begin
      chk("held_ack_count0", ack_cnt[0] - base0, 1);
      chk("held_ack_cycle0", last_ack[0] - rel, 81);
      chk("held_ack_count1", ack_cnt[1] - base1, 1);
      chk("held_ack_cycle1", last_ack[1] - rel, 83);
    end
    model_font();
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr = 1'b1; wr_addr = a; wr_data = d;
    mdl[a] = d;
    known[a] = 1'b1;
    next_cycle();
    wr = 1'b0;
  endtask

  task automatic do_read(input int i, input logic [AW-1:0] a);
    int issue;
    int base;
    bit got;
    push_exp(i, mdl[a]);
    issue = cyc;
    base = ack_cnt[i];
    got = 1'b0;
    rd[i] = 1'b1;
    rd_addr[i] = a;
    for (int k = 0; k < 20 && !got; k++) begin
      next_cycle();
      if (ack_cnt[i] != base) got = 1'b1;
    end
    rd[i] = 1'b0;
    if (!got) begin
      chk("read_timeout", 0, 1);
      if (i == 0) exp_q0.delete(); else exp_q1.delete();
    end else begin
      chk("read_latency", last_ack[i] - issue, lat(i));
    end
  endtask

  // main sequence
  initial begin
    int c;
    int t;
    int first;
    int base;
    logic [AW-1:0] a;
    for (int k = 0; k < 4096; k++) known[k] = 1'b0;
    ack_cnt[0] = 0; ack_cnt[1] = 0; last_ack[0] = 0; last_ack[1] = 0;
    reset = 1'b1;
    rd[0] = 1'b0; rd[1] = 1'b0; rd_addr[0] = '0; rd_addr[1] = '0;
    wr = 1'b0; wr_addr = '0; wr_data = '0;
    repeat (3) next_cycle();
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("reset_rdata", int'(rdata[i]), 0);
      chk("reset_ack", int'(ack[i]), 0);
      chk("reset_init_done", int'(done[i]), 0);
    end
    next_cycle();

    // preload timing, held read during INIT, dropped INIT write at 0x050
    init_phase(1'b1);
    do_read(0, 12'h050);
    do_read(0, 12'h051);
    do_read(0, 12'h09F);
    do_read(1, 12'h050);

    // write then back-to-back reads on the latency-1 instance
    c = cyc;
    do_write(12'h200, 8'hA2);
    push_exp(0, 8'hA2);
    push_exp(0, 8'hA2);
    base = ack_cnt[0];
    first = -1;
    rd[0] = 1'b1; rd_addr[0] = 12'h200;
    for (int k = 0; k < 20 && ack_cnt[0] < base + 2; k++) begin
      next_cycle();
      if (first < 0 && ack_cnt[0] > base) first = last_ack[0];
    end
    rd[0] = 1'b0;
    chk("b2b_ack_count", ack_cnt[0] - base, 2);
    chk("b2b_first_ack", first - c, 2);
    chk("b2b_second_ack", last_ack[0] - c, 4);

    // write-first forwarding inside the latency window on the latency-3 instance
    do_write(12'h300, 8'h11);
    t = cyc;
    base = ack_cnt[1];
    rd[1] = 1'b1; rd_addr[1] = 12'h300;
    mdl[12'h300] = 8'h5C;
    push_exp(1, 8'h5C);
    next_cycle();
    next_cycle();
    wr = 1'b1; wr_addr = 12'h300; wr_data = 8'h5C;
    next_cycle();
    wr = 1'b0;
    next_cycle();
    rd[1] = 1'b0;
    chk("fwd_ack_count", ack_cnt[1] - base, 1);
    chk("fwd_ack_cycle", last_ack[1] - t, 3);

    // randomized traffic
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 2) == 0) begin
        do_write(AW'(12'h200 + $urandom_range(0, 15)), DW'($urandom_range(0, 255)));
      end else begin
        if ($urandom_range(0, 1) == 0) a = AW'(12'h050 + $urandom_range(0, 79));
        else a = AW'(12'h200 + $urandom_range(0, 15));
        if (!known[a]) a = AW'(12'h050 + $urandom_range(0, 79));
        do_read(int'($urandom_range(0, 1)), a);
      end
      repeat ($urandom_range(0, 2)) next_cycle();
    end

    // reset while a latency-3 read is outstanding
    rd[1] = 1'b1; rd_addr[1] = 12'h300;
    next_cycle();
    reset = 1'b1;
    rd[1] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("rst_rdata0", int'(rdata[0]), 0);
      chk("rst_rdata1", int'(rdata[1]), 0);
      chk("rst_init_done0", int'(done[0]), 0);
      chk("rst_init_done1", int'(done[1]), 0);
      next_cycle();
    end
    init_phase(1'b0);
    do_read(1, 12'h300);
    do_read(0, 12'h09F);
    do_read(1, 12'h05A);

    repeat (5) next_cycle();
    chk("queue0_empty", exp_q0.size(), 0);
    chk("queue1_empty", exp_q1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

endmodule
